// File: rtl/memory_bus_arbiter_if.sv
// Bundles the requester-side and memory-side channels of the memory bus arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface memory_bus_arbiter_if #(
    parameter int NUM_MASTERS     = 4,
    parameter int DATA_WIDTH      = 24,
    parameter int ADDRESS_WIDTH   = 32,
    parameter int MASTER_ID_WIDTH = 8
);
    logic [NUM_MASTERS-1:0][ADDRESS_WIDTH-1:0] reqAddress;
    logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]    reqData;
    logic [NUM_MASTERS-1:0]                    reqWrite;
    logic [NUM_MASTERS-1:0]                    reqValid;
    logic [NUM_MASTERS-1:0]                    reqReady;
    logic [DATA_WIDTH-1:0]                     rspData;
    logic [NUM_MASTERS-1:0]                    rspValid;
    logic [NUM_MASTERS-1:0]                    rspReady;
    logic [MASTER_ID_WIDTH-1:0]                msID;
    logic [ADDRESS_WIDTH-1:0]                  msAddress;
    logic [DATA_WIDTH-1:0]                     msData;
    logic                                      msWrite;
    logic                                      msValid;
    logic                                      msReady;
    logic [MASTER_ID_WIDTH-1:0]                smID;
    logic [DATA_WIDTH-1:0]                     smData;
    logic                                      smValid;
    logic                                      smReady;
    logic                                      badId;

    // Handshakes: a beat transfers on a clock edge where valid and ready are both high;
    // valid never waits on ready, and a held beat stays stable until it transfers.
    modport master (
        output reqAddress, reqData, reqWrite, reqValid, rspReady, msReady, smID, smData, smValid,
        input  reqReady, rspData, rspValid, msID, msAddress, msData, msWrite, msValid, smReady, badId
    );

    modport slave (
        input  reqAddress, reqData, reqWrite, reqValid, rspReady, msReady, smID, smData, smValid,
        output reqReady, rspData, rspValid, msID, msAddress, msData, msWrite, msValid, smReady, badId
    );
endinterface

// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter sharing one memory request channel among NUM_MASTERS ports,
// with a one-entry registered output stage and ID-routed combinational responses.
module memory_bus_arbiter #(
    parameter int NUM_MASTERS     = 4,
    parameter int DATA_WIDTH      = 24,
    parameter int ADDRESS_WIDTH   = 32,
    parameter int MASTER_ID_WIDTH = 8
) (
    input  logic                clock,
    input  logic                reset,
    memory_bus_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(NUM_MASTERS - 1);
    localparam logic [MASTER_ID_WIDTH:0] PORT_LIMIT = (MASTER_ID_WIDTH + 1)'(NUM_MASTERS);

    logic                       ms_valid_q;
    logic [MASTER_ID_WIDTH-1:0] ms_id_q;
    logic [ADDRESS_WIDTH-1:0]   ms_address_q;
    logic [DATA_WIDTH-1:0]      ms_data_q;
    logic                       ms_write_q;
    logic [IDX_W-1:0]           last_q;
    logic                       bad_id_q;

    logic [IDX_W-1:0]           grant;
    logic                       any_valid;
    logic                       load;
    int                         scan;
    logic                       id_ok;
    logic [IDX_W-1:0]           sm_port;

    assign load = !ms_valid_q || bus.msReady;

    // First valid port after the previous winner, wrapping around.
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        scan      = 0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            scan = (int'(last_q) + k) % NUM_MASTERS;
            if (!any_valid && bus.reqValid[scan]) begin
                any_valid = 1'b1;
                grant     = IDX_W'(scan);
            end
        end
    end

    assign bus.reqReady = (load && any_valid) ? (NUM_MASTERS'(1) << grant) : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ms_valid_q   <= 1'b0;
            ms_id_q      <= '0;
            ms_address_q <= '0;
            ms_data_q    <= '0;
            ms_write_q   <= 1'b0;
            last_q       <= LAST_PORT;
        end else if (load) begin
            if (any_valid) begin
                ms_valid_q   <= 1'b1;
                ms_id_q      <= MASTER_ID_WIDTH'(grant);
                ms_address_q <= bus.reqAddress[grant];
                ms_data_q    <= bus.reqData[grant];
                ms_write_q   <= bus.reqWrite[grant];
                last_q       <= grant;
            end else begin
                ms_valid_q <= 1'b0;
            end
        end
    end

    assign bus.msValid   = ms_valid_q;
    assign bus.msID      = ms_id_q;
    assign bus.msAddress = ms_address_q;
    assign bus.msData    = ms_data_q;
    assign bus.msWrite   = ms_write_q;

    // Responses with an out-of-range ID are accepted and dropped so the bus never locks up.
    assign id_ok   = {1'b0, bus.smID} < PORT_LIMIT;
    assign sm_port = bus.smID[IDX_W-1:0];

    always_comb begin
        bus.rspValid = '0;
        bus.smReady  = 1'b1;
        if (id_ok) begin
            bus.rspValid[sm_port] = bus.smValid;
            bus.smReady           = bus.rspReady[sm_port];
        end
    end

    assign bus.rspData = bus.smData;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bad_id_q <= 1'b0;
        end else if (bus.smValid && !id_ok) begin
            bad_id_q <= 1'b1;
        end
    end

    assign bus.badId = bad_id_q;
endmodule

// File: doc/memory_bus_arbiter.md
Name: memory_bus_arbiter

Overview:
- Shares one memory bus between NUM_MASTERS requesters, e.g. several ray memory units plus a pixel writer, in front of a single memory controller.
- Request channel: round-robin arbitration into a one-entry registered output stage. The arbiter stamps the winning port index onto the request ID.
- Response channel: routed combinationally to the requester whose port index equals the response ID.

Parameters:
- NUM_MASTERS, 4, number of requester ports (2..16).
- DATA_WIDTH, 24, data width of both channels.
- ADDRESS_WIDTH, 32, request address width.
- MASTER_ID_WIDTH, 8, bus ID width; must satisfy 2^MASTER_ID_WIDTH >= NUM_MASTERS.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- reqAddress  in  NUM_MASTERS x ADDRESS_WIDTH  per-port request address.
- reqData  in  NUM_MASTERS x DATA_WIDTH  per-port write data.
- reqWrite  in  NUM_MASTERS  per-port write (1) / read (0).
- reqValid  in  NUM_MASTERS  per-port request valid.
- reqReady  out  NUM_MASTERS  per-port request accepted.
- rspData  out  DATA_WIDTH  response data, broadcast to all ports.
- rspValid  out  NUM_MASTERS  per-port response valid.
- rspReady  in  NUM_MASTERS  per-port response ready.
- msID  out  MASTER_ID_WIDTH  downstream request ID (granted port index).
- msAddress  out  ADDRESS_WIDTH  downstream address.
- msData  out  DATA_WIDTH  downstream write data.
- msWrite  out  1  downstream write flag.
- msValid  out  1  downstream request valid.
- msReady  in  1  downstream request ready.
- smID  in  MASTER_ID_WIDTH  response ID.
- smData  in  DATA_WIDTH  response data.
- smValid  in  1  response valid.
- smReady  out  1  response ready.
- badId  out  1  sticky flag: a response arrived with smID >= NUM_MASTERS.

Behaviour:
- Reset (async, active-high) values:
  - msValid=0; msID, msAddress, msData and msWrite = 0.
  - badId=0.
  - Round-robin pointer last = NUM_MASTERS-1, so port 0 has first priority.
- load = !msValid || msReady. The output register may take a new request this cycle.
- Arbitration, combinational:
  - Scan ports last+1, last+2, ... with wrap-around modulo NUM_MASTERS.
  - grant = first port with reqValid=1.
- reqReady[i] = load && anyValid && (grant==i). At most one bit is set per cycle.
- On a clock edge with load && anyValid:
  - msValid<=1, msID<=grant (zero-extended), msAddress/msData/msWrite <= that port's fields.
  - last<=grant.
- On load && !anyValid: msValid<=0. Payload registers and last hold.
- While msValid && !msReady: the output register holds stable and all reqReady=0.
- Request latency is 1 cycle from acceptance to msValid. Back-to-back throughput is 1 request per cycle when msReady stays high.
- Requesters may drop or change reqValid freely. There is no lock; grant is re-evaluated every cycle.
- Response routing, combinational with no added latency:
  - If smID < NUM_MASTERS: rspValid[smID]=smValid, all other rspValid bits 0, smReady=rspReady[smID].
  - Otherwise all rspValid=0, smReady=1 (beat dropped), and badId<=1 on the edge if smValid.
- rspData = smData at all times.
- Request and response channels are independent. Simultaneous activity on both never stalls either.
- badId clears only on reset.
- Reset asserted mid-transfer discards the held request. msValid drops immediately (asynchronous).

Test Plan:
- Reset, then port 2 only: reqValid=0100, addr 0x100, write=1, data 0xABCDEF -> reqReady[2]=1 the same cycle. Next cycle msValid=1, msID=2, msAddress=0x100, msData=0xABCDEF, msWrite=1.
- All four ports request continuously with msReady=1 -> grants 0,1,2,3,0,1 on consecutive cycles. msID follows one cycle later.
- Backpressure: msValid=1 and msReady=0 for 5 cycles with ports 1 and 3 requesting -> msID and address stable, reqReady=0000. When msReady=1, port 3 is granted (last=1).
- Response routing: smID=3, smValid=1, smData=0x123456, rspReady=1000 -> rspValid=1000, rspData=0x123456, smReady=1. With rspReady[3]=0 -> smReady=0.
- Bad ID: smID=9, smValid=1, all rspReady=0 -> smReady=1, rspValid=0000. badId=1 next cycle and stays set until reset.
- Reset asserted while msValid=1 and msReady=0 -> msValid=0 immediately. After release, port 0 has priority.
